// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - First-word fall-through receive FIFO behind a UART receiver
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN (enables the watermark_o fill-level flag)
module uart_rx_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    parameter int Watermark = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_tick_i,
    input  logic [DataWidth-1:0]       wr_data_i,
    input  logic                       rd_i,
    output logic [DataWidth-1:0]       rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       overflow_o,
    input  logic                       overflow_clr_i,
    output logic                       watermark_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 drop;

    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_CNT);

    // A full FIFO still takes a write when a pop frees the head slot in the same cycle.
    assign rd_acc = rd_i & ~empty_o;
    assign wr_acc = wr_tick_i & (~full_o | rd_i);
    assign drop   = wr_tick_i & full_o & ~rd_i;

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            // Set beats clear so a byte lost in the clearing cycle is never hidden.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow <= 1'b0;
            end
        end
    end

    assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];
    assign count_o    = count;
    assign overflow_o = overflow;

`ifdef UART_RX_FIFO_WATERMARK_EN
    assign watermark_o = (count >= CW'(Watermark));
`else
    assign watermark_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Scoreboard testbench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_tick = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic       watermark;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic       wm_en;

    uart_rx_fifo #(.DataWidth(8), .Depth(16), .Watermark(8)) dut (
        .clk_i(clk), .rst_i(rst), .wr_tick_i(wr_tick), .wr_data_i(wr_data),
        .rd_i(rd), .rd_data_o(rd_data), .empty_o(empty), .full_o(full),
        .count_o(count), .overflow_o(overflow), .overflow_clr_i(overflow_clr),
        .watermark_o(watermark)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] d);
        wr_tick = 1'b1;
        wr_data = d;
        if (q.size() < 16) q.push_back(d);
        step();
        wr_tick = 1'b0;
    endtask

    task automatic do_pop(output logic [7:0] got, output logic [7:0] exp);
        got = rd_data;
        exp = (q.size() > 0) ? q.pop_front() : 8'h00;
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic drain();
        logic [7:0] g, e;
        while (q.size() > 0) begin
            do_pop(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL drain_data got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({count, empty, full, overflow, watermark, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state count=%0d empty=%b full=%b ovf=%b wm=%b data=%h", count, empty, full, overflow, watermark, rd_data);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ordering();
        logic [7:0] g, e;
        logic [7:0] vals [3];
        vals = '{8'hA5, 8'h3C, 8'hFF};
        for (int i = 0; i < 3; i++) do_push(vals[i]);
        checks++;
        if (count !== 5'd3) begin errors++; $display("FAIL order_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            do_pop(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL order_data got=%h exp=%h", g, e); end
            checks++;
            if (count !== 5'(2 - i)) begin errors++; $display("FAIL order_count got=%0d exp=%0d", count, 2 - i); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] g, e;
        for (int i = 0; i < 16; i++) do_push(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full full=%b count=%0d exp full=1 count=16", full, count); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        do_push(8'hEE);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_set ovf=%b count=%0d exp ovf=1 count=16", overflow, count); end
        for (int i = 0; i < 16; i++) begin
            do_pop(g, e);
            checks++;
            if (g !== 8'(i) || g !== e) begin errors++; $display("FAIL ovf_drain got=%h exp=%h", g, 8'(i)); end
        end
        checks++;
        if (empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL ovf_empty empty=%b data=%h exp empty=1 data=00", empty, rd_data); end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] g, e;
        for (int i = 0; i < 16; i++) do_push(8'h40 + 8'(i));
        g = rd_data;
        e = q.pop_front();
        q.push_back(8'h77);
        wr_tick = 1'b1; wr_data = 8'h77; rd = 1'b1;
        step();
        wr_tick = 1'b0; rd = 1'b0;
        checks++;
        if (g !== e) begin errors++; $display("FAIL simul_full_head got=%h exp=%h", g, e); end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL simul_full count=%0d ovf=%b exp count=16 ovf=0", count, overflow); end
        for (int i = 0; i < 16; i++) begin
            do_pop(g, e);
            checks++;
            if (g !== e) begin errors++; $display("FAIL simul_drain got=%h exp=%h", g, e); end
        end
        checks++;
        if (g !== 8'h77) begin errors++; $display("FAIL simul_last got=%h exp=77", g); end
        q.push_back(8'h99);
        wr_tick = 1'b1; wr_data = 8'h99; rd = 1'b1;
        step();
        wr_tick = 1'b0; rd = 1'b0;
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h99) begin errors++; $display("FAIL simul_empty count=%0d data=%h exp count=1 data=99", count, rd_data); end
        drain();
    endtask

    task automatic test_wrap();
        logic [7:0] g, e;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            do_push(8'(i * 7 + 3));
            checks++;
            if (rd_data !== 8'(i * 7 + 3) || empty !== 1'b0) begin
                errors++; $display("FAIL wrap_latency got=%h empty=%b exp=%h", rd_data, empty, 8'(i * 7 + 3));
            end
            do_pop(g, e);
            if (g !== e) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_order bad_pops=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] g, e;
        for (int i = 0; i < 17; i++) do_push(8'h80 + 8'(i));
        for (int i = 0; i < 11; i++) do_pop(g, e);
        checks++;
        if (count !== 5'd5 || overflow !== 1'b1) begin errors++; $display("FAIL rstmid_pre count=%0d ovf=%b exp count=5 ovf=1", count, overflow); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_async count=%0d empty=%b ovf=%b data=%h exp 0/1/0/00", count, empty, overflow, rd_data);
        end
        q.delete();
        step();
        step();
        rst = 1'b0;
        do_push(8'h5A);
        do_pop(g, e);
        checks++;
        if (g !== 8'h5A) begin errors++; $display("FAIL rstmid_first got=%h exp=5A", g); end
    endtask

    task automatic test_overflow_clear();
        for (int i = 0; i < 16; i++) do_push(8'(i + 1));
        wr_tick = 1'b1; wr_data = 8'hDD; overflow_clr = 1'b1;
        step();
        wr_tick = 1'b0; overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_priority got=%b exp=1", overflow); end
        step();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_sticky got=%b exp=1", overflow); end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", overflow); end
        drain();
    endtask

    task automatic test_watermark();
        logic [7:0] g, e;
        for (int i = 0; i < 7; i++) do_push(8'hC0 + 8'(i));
        checks++;
        if (watermark !== 1'b0) begin errors++; $display("FAIL wm_7 got=%b exp=0", watermark); end
        do_push(8'hC7);
        checks++;
        if (watermark !== wm_en) begin errors++; $display("FAIL wm_8 got=%b exp=%b", watermark, wm_en); end
        do_pop(g, e);
        checks++;
        if (watermark !== 1'b0) begin errors++; $display("FAIL wm_pop got=%b exp=0", watermark); end
        drain();
    endtask

    initial begin
`ifdef UART_RX_FIFO_WATERMARK_EN
        wm_en = 1'b1;
`else
        wm_en = 1'b0;
`endif
        test_reset();
        test_ordering();
        test_fill_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_overflow_clear();
        test_watermark();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
